// File: rtl/gray_window_3x3.sv
// 3x3 neighbourhood generator for a raster-order grayscale stream: two line
// buffers feed a 3x3 shift window; dout_valid flags fully in-frame windows.
module gray_window_3x3 #(
    parameter int INT_WIDTH  = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INT_WIDTH-1:0]   din,
    input  logic                   din_valid,
    output logic [9*INT_WIDTH-1:0] window,
    output logic                   dout_valid,
    output logic                   frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic [COL_W-1:0]     col_nxt_s;
    logic [ROW_W-1:0]     row_nxt_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic                 accept_s;
    logic                 in_frame_s;
    logic [INT_WIDTH-1:0] lb0_r [IMG_WIDTH];
    logic [INT_WIDTH-1:0] lb1_r [IMG_WIDTH];
    logic [INT_WIDTH-1:0] lb0_rd_s;
    logic [INT_WIDTH-1:0] lb1_rd_s;
    logic [9*INT_WIDTH-1:0] window_r;
    logic                 dout_valid_r;
    logic                 frame_done_r;

    assign accept_s = din_valid & ~rst;
    assign lb0_rd_s = lb0_r[col_r];
    assign lb1_rd_s = lb1_r[col_r];

    // Raster position bookkeeping: next column/row and wrap detection.
    always_comb begin
        col_last_s = (col_r == COL_W'(IMG_WIDTH - 1));
        row_last_s = (row_r == ROW_W'(IMG_HEIGHT - 1));
        in_frame_s = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));
        if (col_last_s) begin
            col_nxt_s = COL_W'(0);
            if (row_last_s) begin
                row_nxt_s = ROW_W'(0);
            end else begin
                row_nxt_s = row_r + ROW_W'(1);
            end
        end else begin
            col_nxt_s = col_r + COL_W'(1);
            row_nxt_s = row_r;
        end
    end

    // Line buffers: storage only, never reset; stale data is masked by in_frame_s.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[col_r] <= lb0_rd_s;
            lb0_r[col_r] <= din;
        end
    end

    // Counters, shift window and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r        <= COL_W'(0);
            row_r        <= ROW_W'(0);
            window_r     <= '0;
            dout_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (din_valid) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            for (int r = 0; r < 3; r++) begin
                window_r[(3*r)*INT_WIDTH   +: INT_WIDTH] <= window_r[(3*r+1)*INT_WIDTH +: INT_WIDTH];
                window_r[(3*r+1)*INT_WIDTH +: INT_WIDTH] <= window_r[(3*r+2)*INT_WIDTH +: INT_WIDTH];
            end
            // New right-hand column: oldest line on top, incoming pixel at bottom.
            window_r[2*INT_WIDTH +: INT_WIDTH] <= lb1_rd_s;
            window_r[5*INT_WIDTH +: INT_WIDTH] <= lb0_rd_s;
            window_r[8*INT_WIDTH +: INT_WIDTH] <= din;
            dout_valid_r <= in_frame_s;
            frame_done_r <= row_last_s & col_last_s;
        end else begin
            dout_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    assign window     = window_r;
    assign dout_valid = dout_valid_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Self-checking bench for gray_window_3x3: a 4x4 instance checked against an
// image-array scoreboard plus a table of frame scenarios, and a larger all-255 instance.
module tb_gray_window_3x3;

    logic        clk = 1'b0;
    logic        rst, din_valid, dout_valid, frame_done;
    logic [7:0]  din;
    logic [71:0] window;

    logic        b_rst, b_valid, b_dv, b_fd;
    logic [7:0]  b_din;
    logic [71:0] b_win;

    always #5 clk = ~clk;

    gray_window_3x3 #(.INT_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .window(window), .dout_valid(dout_valid), .frame_done(frame_done)
    );

    gray_window_3x3 #(.INT_WIDTH(8), .IMG_WIDTH(20), .IMG_HEIGHT(8)) u_big (
        .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_valid),
        .window(b_win), .dout_valid(b_dv), .frame_done(b_fd)
    );

    typedef struct {
        int          base;
        bit          gap;
        int          pulses;
        logic [71:0] first_w;
        logic [71:0] last_w;
    } vec_t;

    vec_t        tbl [4];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  img [4][4];
    int          mr = 0, mc = 0;
    logic [72:0] sb_q [$];
    int          pulses, fd_cnt, min_lane, seen;
    logic [71:0] first_w, last_w;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        pulses = 0; fd_cnt = 0; min_lane = 255; seen = 0;
        first_w = '0; last_w = '0;
    endtask

    // One clock: drive, update the model at the edge, then check #1 later.
    task automatic step(input logic v, input logic [7:0] p, input logic r);
        logic        exp_v, exp_fd;
        logic [71:0] w;
        logic [72:0] e;
        din = p; din_valid = v; rst = r;
        @(posedge clk);
        exp_v = 1'b0; exp_fd = 1'b0; w = '0;
        if (r) begin
            mr = 0; mc = 0;
        end else if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
                exp_v  = 1'b1;
                exp_fd = (mr == 3 && mc == 3);
                sb_q.push_back({exp_fd, w});
            end
            mc++;
            if (mc == 4) begin
                mc = 0; mr++;
                if (mr == 4) mr = 0;
            end
        end
        #1;
        chk("dout_valid", {71'd0, dout_valid}, {71'd0, exp_v});
        chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
        if (dout_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 72'd1, 72'd0);
            end else begin
                e = sb_q.pop_front();
                chk("window", window, e[71:0]);
            end
            pulses++;
            if (seen == 0) first_w = window;
            seen = 1;
            last_w = window;
            for (int k = 0; k < 9; k++)
                if (int'(window[k*8 +: 8]) < min_lane) min_lane = int'(window[k*8 +: 8]);
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic check_frame(input int idx, input vec_t t);
        chk($sformatf("pulses[%0d]", idx), 72'(pulses), 72'(t.pulses));
        chk($sformatf("frame_done_cnt[%0d]", idx), 72'(fd_cnt), 72'd1);
        chk($sformatf("first_win[%0d]", idx), first_w, t.first_w);
        chk($sformatf("last_win[%0d]", idx), last_w, t.last_w);
        chk($sformatf("min_lane_ok[%0d]", idx), {71'd0, min_lane >= t.base}, 72'd1);
    endtask

    initial begin
        int bcnt, bbad, bfd, bfd_k;
        tbl[0] = '{0,   1'b0, 4, {8'd10,8'd9,8'd8,8'd6,8'd5,8'd4,8'd2,8'd1,8'd0},
                                 {8'd15,8'd14,8'd13,8'd11,8'd10,8'd9,8'd7,8'd6,8'd5}};
        tbl[1] = '{0,   1'b1, 4, {8'd10,8'd9,8'd8,8'd6,8'd5,8'd4,8'd2,8'd1,8'd0},
                                 {8'd15,8'd14,8'd13,8'd11,8'd10,8'd9,8'd7,8'd6,8'd5}};
        tbl[2] = tbl[0];
        tbl[3] = '{100, 1'b0, 4, {8'd110,8'd109,8'd108,8'd106,8'd105,8'd104,8'd102,8'd101,8'd100},
                                 {8'd115,8'd114,8'd113,8'd111,8'd110,8'd109,8'd107,8'd106,8'd105}};
        b_rst = 1'b1; b_valid = 1'b0; b_din = 8'd0;
        rst = 1'b1; din_valid = 1'b0; din = 8'd0;

        // Reset held two cycles.
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("reset_window", window, 72'd0);

        // Table scenarios; entries 2 and 3 run back to back with no idle cycle.
        for (int t = 0; t < 4; t++) begin
            clear_stats();
            for (int i = 0; i < 16; i++) begin
                step(1'b1, 8'(tbl[t].base + i), 1'b0);
                if (tbl[t].gap) step(1'b0, 8'hEE, 1'b0);
            end
            check_frame(t, tbl[t]);
        end

        // Partial frame, reset (with a simultaneous pixel that must be dropped), full frame.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        chk("midreset_window", window, 72'd0);
        clear_stats();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        check_frame(4, tbl[0]);
        chk("sb_drained", 72'(sb_q.size()), 72'd0);

        // Larger non-power-of-two frame of all 255.
        @(negedge clk); b_rst = 1'b1;
        @(negedge clk);
        @(negedge clk); b_rst = 1'b0;
        bcnt = 0; bbad = 0; bfd = 0; bfd_k = -1;
        for (int k = 0; k < 160; k++) begin
            b_din = 8'hFF; b_valid = 1'b1;
            @(posedge clk); #1;
            if (b_dv) begin
                bcnt++;
                if (b_win !== {9{8'hFF}}) bbad++;
            end
            if (b_fd) begin
                bfd++; bfd_k = k;
                if (!b_dv) bbad++;
            end
        end
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("big_idle_dv", {71'd0, b_dv}, 72'd0);
        chk("big_valid_cnt", 72'(bcnt), 72'd108);
        chk("big_bad_lanes", 72'(bbad), 72'd0);
        chk("big_fd_cnt", 72'(bfd), 72'd1);
        chk("big_fd_pos", 72'(bfd_k), 72'd159);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
